clk_divider_prog: RTL and testbench

Runtime-programmable integer clock divider. It is the parametrised successor of the fixed 2^n divider and supports any ratio N from 2 to 2^CNT_W-1. It produces a divided level output clk_div plus a one-cycle enable strobe clk_tick, so downstream logic (SPI/W5500 timing, polling timers) can stay in the single clk domain. The ratio is reloaded through a shadow register, and a new ratio only takes effect on a period boundary, so clk_div never produces a runt pulse.

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_shadow_reg.sv | 68 ++++++
 rtl/clk_divider_prog.sv | 89 ++++++++
 tb/tb_clk_divider_prog.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

   // Smallest legal division ratio
   localparam int unsigned DIV_MIN   = 2;
   // Default width of the ratio and period counter
   localparam int unsigned CNT_W_DEF = 16;

   // First count value of the high phase: low phase is the larger half for odd N
   function automatic int unsigned high_thresh(input int unsigned n);
      return n - (n >> 1);
   endfunction

endpackage

// File: rtl/clk_div_shadow_reg.sv
// Shadow ratio register: holds a pending ratio and applies it only on a
// period boundary (or at once while the counter is held by en=0).
module clk_div_shadow_reg
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned DIV_RESET = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wrap,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_busy,
   output logic             div_ack,
   output logic             div_err,
   output logic [CNT_W-1:0] div_cur
);

   logic [CNT_W-1:0] pend_q, pend_d;
   logic [CNT_W-1:0] cur_q, cur_d;
   logic             busy_q, busy_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             load_ok;
   logic             apply;

   // Next-state: a fresh load always wins the pending slot, even on an apply edge
   always_comb begin
      load_ok = div_load && (32'(div_val) >= DIV_MIN);
      apply   = busy_q && (wrap || !en);
      pend_d  = pend_q;
      busy_d  = busy_q;
      cur_d   = apply ? pend_q : cur_q;
      ack_d   = apply;
      err_d   = div_load && !load_ok;
      if (load_ok) begin
         pend_d = div_val;
         busy_d = 1'b1;
      end else if (apply) begin
         busy_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         cur_q  <= CNT_W'(DIV_RESET);
         busy_q <= 1'b0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         cur_q  <= cur_d;
         busy_q <= busy_d;
         ack_q  <= ack_d;
         err_q  <= err_d;
      end
   end

   assign div_busy = busy_q;
   assign div_ack  = ack_q;
   assign div_err  = err_q;
   assign div_cur  = cur_q;

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with level output and tick strobe.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a negedge copy of clk_div so odd
// ratios get exactly 50% duty; clk_div then becomes a clock-only output.
module clk_divider_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned DIV_RESET = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_busy,
   output logic             div_ack,
   output logic             div_err,
   output logic [CNT_W-1:0] div_cur,
   output logic             clk_div,
   output logic             clk_tick
);

   if ((CNT_W < 2) || (CNT_W > 31) || (DIV_RESET < DIV_MIN) ||
       (DIV_RESET > ((32'd1 << CNT_W) - 32'd1))) begin : g_bad_param
      $error("clk_divider_prog: DIV_RESET out of range for CNT_W");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_div_q, clk_div_d;
   logic             clk_tick_q, clk_tick_d;
   logic             wrap;

   clk_div_shadow_reg #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
   ) u_shadow (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .wrap     (wrap),
      .div_val  (div_val),
      .div_load (div_load),
      .div_busy (div_busy),
      .div_ack  (div_ack),
      .div_err  (div_err),
      .div_cur  (div_cur)
   );

   // Counter and outputs derived from the next count so they align with it
   always_comb begin
      wrap       = en && (cnt_q == div_cur - CNT_W'(1));
      cnt_d      = (!en || wrap) ? '0 : cnt_q + CNT_W'(1);
      clk_div_d  = en && (32'(cnt_d) >= high_thresh(32'(div_cur)));
      clk_tick_d = wrap;
   end

   // Counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         clk_div_q  <= 1'b0;
         clk_tick_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         clk_div_q  <= clk_div_d;
         clk_tick_q <= clk_tick_d;
      end
   end

`ifdef CLK_DIV_ODD_DUTY50_EN
   logic clk_div_n_q;

   // Half-cycle delayed copy stretches the odd-N high phase by half a clock
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_div_n_q <= 1'b0;
      end else begin
         clk_div_n_q <= clk_div_q;
      end
   end

   assign clk_div = div_cur[0] ? (clk_div_q | clk_div_n_q) : clk_div_q;
`else
   assign clk_div = clk_div_q;
`endif

   assign clk_tick = clk_tick_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: a cycle model pushes expected
// outputs to a queue as stimulus is driven; each scenario pops and compares.
module tb_clk_divider_prog;
   import clk_div_pkg::*;

   localparam int unsigned CW = CNT_W_DEF;
   localparam int unsigned DR = 4;

   typedef struct packed {
      logic          busy;
      logic          ack;
      logic          err;
      logic [CW-1:0] cur;
      logic          div;
      logic          tick;
   } obs_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [CW-1:0] div_val;
   logic          div_load;
   logic          div_busy;
   logic          div_ack;
   logic          div_err;
   logic [CW-1:0] div_cur;
   logic          clk_div;
   logic          clk_tick;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model state
   logic [CW-1:0] m_cnt, m_cur, m_pend;
   logic          m_busy, m_ack, m_err, m_div, m_tick;

   clk_divider_prog #(
      .CNT_W     (CW),
      .DIV_RESET (DR)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .div_val  (div_val),
      .div_load (div_load),
      .div_busy (div_busy),
      .div_ack  (div_ack),
      .div_err  (div_err),
      .div_cur  (div_cur),
      .clk_div  (clk_div),
      .clk_tick (clk_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic obs_t obs();
      return {div_busy, div_ack, div_err, div_cur, clk_div, clk_tick};
   endfunction

   function automatic obs_t rst_obs();
      return {1'b0, 1'b0, 1'b0, CW'(DR), 1'b0, 1'b0};
   endfunction

   task automatic model_reset();
      m_cnt  = '0;
      m_cur  = CW'(DR);
      m_pend = '0;
      m_busy = 1'b0;
      m_ack  = 1'b0;
      m_err  = 1'b0;
      m_div  = 1'b0;
      m_tick = 1'b0;
   endtask

   // Advance the model by one edge and queue the outputs expected after it
   task automatic model_step(input logic e, input logic ld, input logic [CW-1:0] v);
      logic          wrap, apply;
      logic [CW-1:0] nc;
      wrap   = e && (m_cnt == m_cur - CW'(1));
      apply  = m_busy && (wrap || !e);
      nc     = (!e || wrap) ? '0 : m_cnt + CW'(1);
      m_div  = e && (32'(nc) >= high_thresh(32'(m_cur)));
      m_tick = wrap;
      m_ack  = apply;
      m_err  = ld && (32'(v) < DIV_MIN);
      if (apply) m_cur = m_pend;
      if (ld && !m_err) begin
         m_pend = v;
         m_busy = 1'b1;
      end else if (apply) begin
         m_busy = 1'b0;
      end
      m_cnt = nc;
      exp_q.push_back({m_busy, m_ack, m_err, m_cur, m_div, m_tick});
   endtask

   // Inputs change on the negedge; returns at the following negedge
   task automatic drive(input logic e, input logic ld, input logic [CW-1:0] v);
      en       = e;
      div_load = ld;
      div_val  = v;
      model_step(e, ld, v);
      @(negedge clk);
   endtask

   task automatic test_reset();
      obs_t o;
      rst_n    = 1'b0;
      en       = 1'b0;
      div_load = 1'b0;
      div_val  = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (obs() !== rst_obs()) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", obs(), rst_obs());
      end
      rst_n = 1'b1;
      model_reset();
      for (int i = 1; i <= 12; i++) begin
         drive(1'b1, 1'b0, '0);
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL reset_run cyc %0d got=%h exp=%h", i, obs(), o);
         end
         checks++;
         if (clk_div !== ((i % 4) >= 2) || clk_tick !== ((i % 4) == 0)) begin
            errors++;
            $display("FAIL div4_pattern cyc %0d got div=%b tick=%b", i, clk_div, clk_tick);
         end
      end
   endtask

   task automatic test_odd_ratio();
      obs_t o;
      bit   found = 1'b0;
      drive(1'b1, 1'b1, CW'(5));
      o = exp_q.pop_front();
      checks++;
      if (obs() !== o) begin
         errors++;
         $display("FAIL odd_load got=%h exp=%h", obs(), o);
      end
      for (int i = 0; i < 10 && !found; i++) begin
         drive(1'b1, 1'b0, '0);
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL odd_wait got=%h exp=%h", obs(), o);
         end
         found = (div_ack === 1'b1);
      end
      if (!found) begin
         errors++;
         $display("FAIL odd_ack_timeout got=no ack exp=ack");
      end
      for (int k = 1; k <= 15; k++) begin
         drive(1'b1, 1'b0, '0);
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL odd_run cyc %0d got=%h exp=%h", k, obs(), o);
         end
         checks++;
         if (clk_div !== ((k % 5) >= 3) || clk_tick !== ((k % 5) == 0) || div_cur !== CW'(5))
         begin
            errors++;
            $display("FAIL div5_pattern cyc %0d got div=%b tick=%b cur=%0d", k, clk_div,
                     clk_tick, div_cur);
         end
      end
   endtask

   task automatic test_boundary_apply();
      obs_t o;
      bit   found = 1'b0;
      drive(1'b1, 1'b1, CW'(8));
      o = exp_q.pop_front();
      checks++;
      if (obs() !== o) begin
         errors++;
         $display("FAIL bnd_load8 got=%h exp=%h", obs(), o);
      end
      for (int i = 0; i < 30 && !(found && m_cnt == CW'(2)); i++) begin
         drive(1'b1, 1'b0, '0);
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL bnd_wait got=%h exp=%h", obs(), o);
         end
         if (div_ack === 1'b1) found = 1'b1;
      end
      checks++;
      if (div_cur !== CW'(8) || m_cnt != CW'(2)) begin
         errors++;
         $display("FAIL bnd_setup got cur=%0d exp cur=8", div_cur);
      end
      for (int j = 1; j <= 6; j++) begin
         drive(1'b1, (j == 1), CW'(3));
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL bnd_apply cyc %0d got=%h exp=%h", j, obs(), o);
         end
         checks++;
         if (div_ack !== (j == 6) || div_busy !== (j != 6) ||
             div_cur !== ((j == 6) ? CW'(3) : CW'(8))) begin
            errors++;
            $display("FAIL bnd_ack_edge cyc %0d got ack=%b busy=%b cur=%0d", j, div_ack,
                     div_busy, div_cur);
         end
      end
      for (int k = 1; k <= 9; k++) begin
         drive(1'b1, 1'b0, '0);
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL bnd_run cyc %0d got=%h exp=%h", k, obs(), o);
         end
         checks++;
         if (clk_div !== ((k % 3) >= 2) || clk_tick !== ((k % 3) == 0)) begin
            errors++;
            $display("FAIL div3_pattern cyc %0d got div=%b tick=%b", k, clk_div, clk_tick);
         end
      end
   endtask

   task automatic test_illegal_load();
      obs_t o;
      for (int j = 0; j < 3; j++) begin
         drive(1'b1, (j < 2), CW'(j));
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL ill_model val %0d got=%h exp=%h", j, obs(), o);
         end
         checks++;
         if (div_err !== (j < 2) || div_busy !== 1'b0 || div_cur !== CW'(3)) begin
            errors++;
            $display("FAIL ill_err val %0d got err=%b busy=%b cur=%0d", j, div_err, div_busy,
                     div_cur);
         end
      end
   endtask

   task automatic test_overwrite_simul();
      obs_t o;
      for (int i = 0; i < 10 && m_cnt != '0; i++) begin
         drive(1'b1, 1'b0, '0);
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL ovr_wait got=%h exp=%h", obs(), o);
         end
      end
      // cnt 0 -> load 6, cnt 1 -> load 10, cnt 2 (wrap) -> load 12
      for (int j = 0; j < 3; j++) begin
         drive(1'b1, 1'b1, (j == 0) ? CW'(6) : (j == 1) ? CW'(10) : CW'(12));
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL ovr_load %0d got=%h exp=%h", j, obs(), o);
         end
         checks++;
         if (div_ack !== (j == 2) || div_busy !== 1'b1 ||
             div_cur !== ((j == 2) ? CW'(10) : CW'(3))) begin
            errors++;
            $display("FAIL ovr_ack %0d got ack=%b busy=%b cur=%0d", j, div_ack, div_busy,
                     div_cur);
         end
      end
      for (int j = 1; j <= 10; j++) begin
         drive(1'b1, 1'b0, '0);
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL simul_run cyc %0d got=%h exp=%h", j, obs(), o);
         end
         checks++;
         if (div_ack !== (j == 10) || div_cur !== ((j == 10) ? CW'(12) : CW'(10))) begin
            errors++;
            $display("FAIL simul_apply cyc %0d got ack=%b cur=%0d", j, div_ack, div_cur);
         end
      end
   endtask

   task automatic test_en_and_reset();
      obs_t o;
      for (int i = 0; i < 20 && m_cnt != CW'(3); i++) begin
         drive(1'b1, 1'b0, '0);
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL en_wait got=%h exp=%h", obs(), o);
         end
      end
      // en drop at cnt=3, reload 7 with en high, then drop en while pending
      for (int j = 0; j < 4; j++) begin
         drive((j == 1 || j == 2), (j == 1), CW'(7));
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL en_seq %0d got=%h exp=%h", j, obs(), o);
         end
      end
      checks++;
      if (div_ack !== 1'b1 || div_cur !== CW'(7) || clk_div !== 1'b0 || clk_tick !== 1'b0) begin
         errors++;
         $display("FAIL en_low_apply got ack=%b cur=%0d div=%b tick=%b", div_ack, div_cur,
                  clk_div, clk_tick);
      end
      for (int j = 0; j < 4; j++) begin
         drive(1'b1, (j == 2), CW'(9));
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL rst_pre %0d got=%h exp=%h", j, obs(), o);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs() !== rst_obs()) begin
         errors++;
         $display("FAIL async_reset got=%h exp=%h", obs(), rst_obs());
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, 1'b0, '0);
         o = exp_q.pop_front();
         checks++;
         if (obs() !== o) begin
            errors++;
            $display("FAIL post_reset cyc %0d got=%h exp=%h", k, obs(), o);
         end
         checks++;
         if (div_ack !== 1'b0 || div_busy !== 1'b0 || div_cur !== CW'(DR)) begin
            errors++;
            $display("FAIL pend_discard cyc %0d got ack=%b busy=%b cur=%0d", k, div_ack,
                     div_busy, div_cur);
         end
      end
   endtask

   initial begin
      test_reset();
      test_odd_ratio();
      test_boundary_apply();
      test_illegal_load();
      test_overwrite_simul();
      test_en_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
